exc_sequencer: RTL

EXC_SEQUENCER -- requirements
Module: exc_sequencer

---
 rtl/exc_sequencer_pkg.sv | 20 ++
 rtl/exc_sequencer_irq_sync.sv | 34 +++
 rtl/exc_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/exc_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exc_sequencer_pkg: shared CPU constants for exception sequencing   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package exc_sequencer_pkg;

    localparam int unsigned C_STATE_W     = 3;
    localparam int unsigned C_EXC_COUNT_W = 16;

    localparam logic [C_STATE_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [C_STATE_W-1:0] ST_EXC_FLUSH  = 3'd1;
    localparam logic [C_STATE_W-1:0] ST_EXC_JUMP   = 3'd2;
    localparam logic [C_STATE_W-1:0] ST_ERET_FLUSH = 3'd3;
    localparam logic [C_STATE_W-1:0] ST_ERET_JUMP  = 3'd4;

    localparam logic [31:0] C_HANDLER_PC_DEFAULT = 32'h0000_4180;

endpackage : exc_sequencer_pkg
`default_nettype wire

// File: rtl/exc_sequencer_irq_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | irq_sync: multi-flop synchroniser for asynchronous interrupt lines |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module irq_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[STAGES-1];

endmodule : irq_sync
`default_nettype wire

// File: rtl/exc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exc_sequencer: flush/redirect sequencing for exceptions and ERET   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module exc_sequencer
    import exc_sequencer_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC  = C_HANDLER_PC_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [5:0]               irq_raw,
    output logic [5:0]               hwint,
    input  logic                     cp0_rupt,
    input  logic                     eret_m,
    input  logic [31:0]              cp0_epc,
    output logic                     flush,
    output logic                     exlclr,
    output logic                     redirect,
    output logic [31:0]              redirect_pc,
    output logic                     busy,
    output logic [C_EXC_COUNT_W-1:0] exc_count
);

    logic [C_STATE_W-1:0]     r_state;
    logic [C_STATE_W-1:0]     w_state_next;
    logic [C_EXC_COUNT_W-1:0] r_exc_count;
    logic                     w_epc_unused;

    irq_sync #(
        .WIDTH  (6),
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (irq_raw),
        .q     (hwint)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Requests are only honoured from IDLE; exceptions take priority over ERET.
    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (cp0_rupt) begin
                    w_state_next = ST_EXC_FLUSH;
                end else if (eret_m) begin
                    w_state_next = ST_ERET_FLUSH;
                end
            end
            ST_EXC_FLUSH:  w_state_next = ST_EXC_JUMP;
            ST_ERET_FLUSH: w_state_next = ST_ERET_JUMP;
            default:       w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        flush       = 1'b0;
        exlclr      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_EXC_FLUSH: begin
                flush = 1'b1;
            end
            ST_EXC_JUMP: begin
                redirect    = 1'b1;
                redirect_pc = HANDLER_PC;
            end
            ST_ERET_FLUSH: begin
                flush  = 1'b1;
                exlclr = 1'b1;
            end
            ST_ERET_JUMP: begin
                redirect    = 1'b1;
                redirect_pc = {cp0_epc[31:2], 2'b00};
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exc_count <= '0;
        end else if ((r_state == ST_IDLE) && cp0_rupt && (r_exc_count != '1)) begin
            r_exc_count <= r_exc_count + 16'd1;
        end
    end

    assign exc_count    = r_exc_count;
    assign w_epc_unused = ^cp0_epc[1:0];

endmodule : exc_sequencer
`default_nettype wire
